// File: rtl/ula_controle_mc_if.sv
// Bus between the main control unit (master) and the registered ALU control decoder (slave).
interface ula_controle_mc_if #(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 4
);
  logic               valid_in;
  logic [OP_W-1:0]    AluOP;
  logic [FUNCT_W-1:0] funct;
  logic [CTRL_W-1:0]  sinal_controle;
  logic               valid_out;
  logic               stall;
  logic               jr_flag;
  logic               illegal;

  modport master (
    output valid_in, AluOP, funct,
    input  sinal_controle, valid_out, stall, jr_flag, illegal
  );

  modport slave (
    input  valid_in, AluOP, funct,
    output sinal_controle, valid_out, stall, jr_flag, illegal
  );
endinterface

// File: rtl/ula_controle_mc.sv
// Registered ALU control decoder; holds the select code and stalls upstream for multi-cycle mul/div.
// Define ULA_EXT_FUNCT_EN to decode R-type funct 9 (xor -> 13) and funct 10 (slt -> 14).
module ula_controle_mc #(
  parameter int OP_W       = 4,
  parameter int FUNCT_W    = 4,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input logic               clock,
  input logic               reset,
  ula_controle_mc_if.slave  bus
);
  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] CODE_MUL  = 4'd4;
  localparam logic [3:0] CODE_DIV  = 4'd5;
  localparam logic [3:0] CODE_DFLT = 4'd15;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] sinal_controle_q, sinal_controle_d;
  logic              valid_out_q, valid_out_d;
  logic              jr_flag_q, jr_flag_d;
  logic              illegal_q, illegal_d;

  logic [3:0]  dec_code;
  logic        dec_jr;
  logic        dec_ill;
  logic [31:0] op_ext;
  logic [31:0] funct_ext;

  // Zero-extend before comparing so narrow AluOP/funct widths never alias onto larger codes.
  assign op_ext    = 32'(bus.AluOP);
  assign funct_ext = 32'(bus.funct);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_code = CODE_DFLT;
    dec_jr   = 1'b0;
    dec_ill  = 1'b0;
    case (op_ext)
      32'd0: dec_code = 4'd2;
      32'd1: begin
        if (bus.funct == '1) begin
          dec_jr = 1'b1;
        end else begin
          case (funct_ext)
            32'd0: dec_code = 4'd0;
            32'd1: dec_code = 4'd1;
            32'd2: dec_code = 4'd2;
            32'd3: dec_code = 4'd3;
            32'd4: dec_code = CODE_MUL;
            32'd5: dec_code = CODE_DIV;
            32'd6: dec_code = 4'd6;
            32'd7: dec_code = 4'd7;
            32'd8: dec_code = 4'd8;
`ifdef ULA_EXT_FUNCT_EN
            32'd9:  dec_code = 4'd13;
            32'd10: dec_code = 4'd14;
`endif
            default: dec_ill = 1'b1;
          endcase
        end
      end
      32'd2:   dec_code = 4'd9;
      32'd3:   dec_code = 4'd10;
      32'd4:   dec_code = 4'd11;
      32'd5:   dec_code = 4'd12;
      32'd6:   dec_code = 4'd0;
      32'd7:   dec_code = 4'd1;
      32'd8:   dec_code = 4'd2;
      32'd9:   dec_code = 4'd3;
      default: dec_ill  = 1'b1;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    sinal_controle_d = sinal_controle_q;
    jr_flag_d        = jr_flag_q;
    illegal_d        = illegal_q;
    valid_out_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          sinal_controle_d = CTRL_W'(dec_code);
          jr_flag_d        = dec_jr;
          illegal_d        = dec_ill;
          if (dec_code == CODE_MUL && MUL_CYCLES > 1) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
          end else if (dec_code == CODE_DIV && DIV_CYCLES > 1) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
          end else begin
            valid_out_d = 1'b1;
          end
        end
      end
      default: begin
        // Upstream is frozen here, so valid_in is deliberately not looked at.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d       = '0;
          valid_out_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      sinal_controle_q <= CTRL_W'(CODE_DFLT);
      valid_out_q      <= 1'b0;
      jr_flag_q        <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      sinal_controle_q <= sinal_controle_d;
      valid_out_q      <= valid_out_d;
      jr_flag_q        <= jr_flag_d;
      illegal_q        <= illegal_d;
    end
  end

  assign bus.sinal_controle = sinal_controle_q;
  assign bus.valid_out      = valid_out_q;
  assign bus.stall          = (state_q == BUSY);
  assign bus.jr_flag        = jr_flag_q;
  assign bus.illegal        = illegal_q;
endmodule

// File: tb/tb_ula_controle_mc.sv
// Directed, table-driven bench for ula_controle_mc with hand-written multi-cycle and reset sequences.
module tb_ula_controle_mc;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  ula_controle_mc_if #(.OP_W(4), .FUNCT_W(4), .CTRL_W(4)) bus ();

  ula_controle_mc #(
    .OP_W(4), .FUNCT_W(4), .CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] op;
    logic [3:0] fn;
    logic [3:0] ctrl;
    logic       jr;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] fn);
    bus.valid_in = v;
    bus.AluOP    = op;
    bus.funct    = fn;
  endtask

  initial begin
    int cyc;
    int stall_cnt;
    int pulses;
    n_cmp  = 0;
    n_fail = 0;

    // Reset held with a valid op pending: nothing may be loaded.
    reset = 1'b0;
    drive(1'b1, 4'd8, 4'd0);
    repeat (3) tick();
    check("rst ctrl",  32'(bus.sinal_controle), 32'd15);
    check("rst valid", 32'(bus.valid_out), 32'd0);
    check("rst stall", 32'(bus.stall), 32'd0);
    check("rst jr",    32'(bus.jr_flag), 32'd0);
    check("rst ill",   32'(bus.illegal), 32'd0);
    reset = 1'b1;

    vecs.push_back('{4'd0,  4'd0,  4'd2,  1'b0, 1'b0});
    vecs.push_back('{4'd2,  4'd0,  4'd9,  1'b0, 1'b0});
    vecs.push_back('{4'd3,  4'd0,  4'd10, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  4'd0,  4'd11, 1'b0, 1'b0});
    vecs.push_back('{4'd5,  4'd0,  4'd12, 1'b0, 1'b0});
    vecs.push_back('{4'd6,  4'd0,  4'd0,  1'b0, 1'b0});
    vecs.push_back('{4'd7,  4'd0,  4'd1,  1'b0, 1'b0});
    vecs.push_back('{4'd8,  4'd0,  4'd2,  1'b0, 1'b0});
    vecs.push_back('{4'd9,  4'd0,  4'd3,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd0,  4'd0,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd1,  4'd1,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd2,  4'd2,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd3,  4'd3,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd6,  4'd6,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd7,  4'd7,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd8,  4'd8,  1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd15, 4'd15, 1'b1, 1'b0});
    vecs.push_back('{4'd12, 4'd0,  4'd15, 1'b0, 1'b1});
    vecs.push_back('{4'd10, 4'd3,  4'd15, 1'b0, 1'b1});
    vecs.push_back('{4'd1,  4'd11, 4'd15, 1'b0, 1'b1});
`ifdef ULA_EXT_FUNCT_EN
    vecs.push_back('{4'd1,  4'd9,  4'd13, 1'b0, 1'b0});
    vecs.push_back('{4'd1,  4'd10, 4'd14, 1'b0, 1'b0});
`else
    vecs.push_back('{4'd1,  4'd9,  4'd15, 1'b0, 1'b1});
    vecs.push_back('{4'd1,  4'd10, 4'd15, 1'b0, 1'b1});
`endif
    vecs.push_back('{4'd6,  4'd0,  4'd0,  1'b0, 1'b0});

    // Back-to-back single-cycle ops: one result per cycle.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].fn);
      tick();
      check($sformatf("vec%0d ctrl", i),  32'(bus.sinal_controle), 32'(vecs[i].ctrl));
      check($sformatf("vec%0d valid", i), 32'(bus.valid_out), 32'd1);
      check($sformatf("vec%0d stall", i), 32'(bus.stall), 32'd0);
      check($sformatf("vec%0d jr", i),    32'(bus.jr_flag), 32'(vecs[i].jr));
      check($sformatf("vec%0d ill", i),   32'(bus.illegal), 32'(vecs[i].ill));
    end

    // No accept: outputs hold, valid_out drops.
    drive(1'b0, 4'd2, 4'd0);
    tick();
    check("hold valid", 32'(bus.valid_out), 32'd0);
    check("hold ctrl",  32'(bus.sinal_controle), 32'd0);

    // Mul: stall for 3 cycles, result on the 4th; andi offered during stall is ignored.
    drive(1'b1, 4'd1, 4'd4);
    tick();
    drive(1'b1, 4'd6, 4'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mul stall%0d", k), 32'(bus.stall), 32'd1);
      check($sformatf("mul valid%0d", k), 32'(bus.valid_out), 32'd0);
      check($sformatf("mul ctrl%0d", k),  32'(bus.sinal_controle), 32'd4);
      tick();
    end
    check("mul done valid", 32'(bus.valid_out), 32'd1);
    check("mul done stall", 32'(bus.stall), 32'd0);
    check("mul done ctrl",  32'(bus.sinal_controle), 32'd4);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    check("mul pulse end", 32'(bus.valid_out), 32'd0);
    check("mul no late accept", 32'(bus.sinal_controle), 32'd4);

    // Div: full 8-cycle latency, counted with a bounded wait.
    drive(1'b1, 4'd1, 4'd5);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    cyc = 1;
    stall_cnt = 0;
    while (!bus.valid_out && cyc < 20) begin
      if (bus.stall) stall_cnt++;
      tick();
      cyc++;
    end
    check("div latency", 32'(cyc), 32'd8);
    check("div stall cycles", 32'(stall_cnt), 32'd7);
    check("div ctrl", 32'(bus.sinal_controle), 32'd5);
    tick();
    check("div pulse end", 32'(bus.valid_out), 32'd0);

    // Reset in the middle of a div drops it immediately.
    drive(1'b1, 4'd1, 4'd5);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    check("rdiv stall", 32'(bus.stall), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rdiv async stall", 32'(bus.stall), 32'd0);
    check("rdiv async ctrl",  32'(bus.sinal_controle), 32'd15);
    check("rdiv async valid", 32'(bus.valid_out), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.valid_out) pulses++;
    end
    check("rdiv no valid", 32'(pulses), 32'd0);
    reset = 1'b1;
    drive(1'b1, 4'd6, 4'd0);
    tick();
    check("post rst ctrl",  32'(bus.sinal_controle), 32'd0);
    check("post rst valid", 32'(bus.valid_out), 32'd1);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    check("post rst idle", 32'(bus.valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
